// File: rtl/rsdec_berl_ibm.sv
// Inversionless Berlekamp-Massey key-equation solver: syndromes in, Lambda/Omega coefficient
// stream out under valid/ready, with the final error count and a failure flag.
module rsdec_berl_ibm #(
  parameter int         NSYM = 32,
  parameter int         M    = 8,
  parameter logic [M:0] POLY = 9'h11D
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            clear,
  input  logic            start,
  input  logic [NSYM*M-1:0] synd_in,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_idx,
  output logic [M-1:0]    lambda_out,
  output logic [M-1:0]    omega_out,
  output logic [6:0]      err_cnt,
  output logic            fail,
  output logic            done
);
  localparam int T = NSYM / 2;

  typedef enum logic [2:0] {IDLE, LOAD, DISC, UPD, OMEGA, OUT} state_t;
  state_t state, state_nxt;

  logic [NSYM*M-1:0] synd;
  logic [M-1:0]      lam   [0:T];
  logic [M-1:0]      bpoly [0:T];
  logic [M-1:0]      omg   [0:T-1];
  logic [M-1:0]      gamma, delta, omega_k;
  logic [6:0]        r, l_reg, deg;
  logic [5:0]        cnt;

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] acc;
    logic [M-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[M-1] ? ((sh << 1) ^ POLY[M-1:0]) : (sh << 1);
    end
    return acc;
  endfunction

  always_comb begin
    delta = '0;
    for (int j = 0; j <= T; j++)
      if (j <= int'(r)) delta = delta ^ gf_mul(lam[j], synd[M*(int'(r)-j) +: M]);
  end

  always_comb begin
    omega_k = '0;
    for (int j = 0; j < T; j++)
      if (j <= int'(cnt)) omega_k = omega_k ^ gf_mul(lam[j], synd[M*(int'(cnt)-j) +: M]);
  end

  always_comb begin
    deg = '0;
    for (int j = 0; j <= T; j++)
      if (lam[j] != '0) deg = 7'(j);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD:  state_nxt = DISC;
      DISC:  state_nxt = UPD;
      UPD:   state_nxt = (r == 7'(NSYM-1)) ? OMEGA : DISC;
      OMEGA: if (cnt == 6'(T-1)) state_nxt = OUT;
      OUT:   if (out_ready && cnt == 6'(T)) begin
               done      = 1'b1;
               state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      synd <= '0; gamma <= 1; l_reg <= '0; r <= '0; cnt <= '0; err_cnt <= '0; fail <= 1'b0;
      for (int k = 0; k <= T; k++) begin
        lam[k]   <= (k == 0) ? M'(1) : '0;
        bpoly[k] <= (k == 0) ? M'(1) : '0;
      end
      for (int k = 0; k < T; k++) omg[k] <= '0;
    end else if (clear) begin
      synd <= '0; gamma <= 1; l_reg <= '0; r <= '0; cnt <= '0; err_cnt <= '0; fail <= 1'b0;
      for (int k = 0; k <= T; k++) begin
        lam[k]   <= (k == 0) ? M'(1) : '0;
        bpoly[k] <= (k == 0) ? M'(1) : '0;
      end
      for (int k = 0; k < T; k++) omg[k] <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          synd    <= synd_in;
          err_cnt <= '0;
          fail    <= 1'b0;
        end
        LOAD: begin
          for (int k = 0; k <= T; k++) begin
            lam[k]   <= (k == 0) ? M'(1) : '0;
            bpoly[k] <= (k == 0) ? M'(1) : '0;
          end
          gamma <= 1; l_reg <= '0; r <= '0; cnt <= '0;
        end
        UPD: begin
          // A zero discrepancy would only rescale Lambda by gamma, so Lambda is held instead
          if (delta != '0) begin
            lam[0] <= gf_mul(gamma, lam[0]);
            for (int k = 1; k <= T; k++)
              lam[k] <= gf_mul(gamma, lam[k]) ^ gf_mul(delta, bpoly[k-1]);
          end
          if (delta != '0 && ({l_reg, 1'b0} <= {1'b0, r})) begin
            for (int k = 0; k <= T; k++) bpoly[k] <= lam[k];
            l_reg <= r + 7'd1 - l_reg;
            gamma <= delta;
          end else begin
            bpoly[0] <= '0;
            for (int k = 1; k <= T; k++) bpoly[k] <= bpoly[k-1];
          end
          r <= r + 7'd1;
        end
        OMEGA: begin
          for (int j = 0; j < T; j++)
            if (cnt == 6'(j)) omg[j] <= omega_k;
          if (cnt == 6'(T-1)) begin
            cnt     <= '0;
            err_cnt <= l_reg;
            fail    <= (l_reg > 7'(T)) || (deg != l_reg);
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        OUT: if (out_ready) cnt <= (cnt == 6'(T)) ? '0 : cnt + 6'd1;
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign out_valid = (state == OUT);
  assign out_idx   = out_valid ? cnt : '0;

  always_comb begin
    lambda_out = '0;
    omega_out  = '0;
    if (out_valid) begin
      for (int j = 0; j <= T; j++)
        if (cnt == 6'(j)) lambda_out = lam[j];
      for (int j = 0; j < T; j++)
        if (cnt == 6'(j)) omega_out = omg[j];
    end
  end
endmodule

// File: tb/tb_rsdec_berl_ibm.sv
// Scoreboard bench for rsdec_berl_ibm: expected coefficient pairs are queued at start and
// compared as the solver hands them out; a second NSYM=4 instance covers the failure flag.
module tb_rsdec_berl_ibm;
  localparam int NSYM = 32;
  localparam int T    = NSYM / 2;

  typedef struct {
    logic [5:0] idx;
    logic [7:0] lam;
    logic [7:0] omg;
    logic       last;
    logic [6:0] err;
    logic       fl;
  } pair_t;

  logic clk = 1'b0;
  logic clrn, clear, start, out_ready;
  logic [NSYM*8-1:0] synd_in;
  logic busy, out_valid, done, fail;
  logic [5:0] out_idx;
  logic [7:0] lambda_out, omega_out;
  logic [6:0] err_cnt;

  logic b_clear, b_start, b_ready;
  logic [31:0] b_synd;
  logic b_busy, b_valid, b_done, b_fail;
  logic [5:0] b_idx;
  logic [7:0] b_lambda, b_omega;
  logic [6:0] b_err;

  pair_t q[$];
  pair_t qb[$];
  pair_t ea, eb;
  int testCount = 0;
  int failCount = 0;
  int readyMode = 0;

  always #5 clk = ~clk;

  rsdec_berl_ibm #(.NSYM(NSYM), .M(8), .POLY(9'h11D)) dut (
    .clk(clk), .clrn(clrn), .clear(clear), .start(start), .synd_in(synd_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .lambda_out(lambda_out), .omega_out(omega_out), .err_cnt(err_cnt), .fail(fail), .done(done)
  );

  rsdec_berl_ibm #(.NSYM(4), .M(8), .POLY(9'h11D)) dut_small (
    .clk(clk), .clrn(clrn), .clear(b_clear), .start(b_start), .synd_in(b_synd),
    .busy(b_busy), .out_valid(b_valid), .out_ready(b_ready), .out_idx(b_idx),
    .lambda_out(b_lambda), .omega_out(b_omega), .err_cnt(b_err), .fail(b_fail), .done(b_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Ready pattern: 0 always ready, 1 toggling every cycle, 2 stalled
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (readyMode)
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (clrn && out_valid && out_ready) begin
      if (q.size() == 0) checkOutput("unexpected_pair", 32'(out_idx), 32'hDEAD);
      else begin
        ea = q.pop_front();
        checkOutput("idx", 32'(out_idx), 32'(ea.idx));
        checkOutput("lambda", 32'(lambda_out), 32'(ea.lam));
        checkOutput("omega", 32'(omega_out), 32'(ea.omg));
        checkOutput("done", 32'(done), 32'(ea.last));
        if (ea.last) begin
          checkOutput("err_cnt", 32'(err_cnt), 32'(ea.err));
          checkOutput("fail", 32'(fail), 32'(ea.fl));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (clrn && b_valid && b_ready) begin
      if (qb.size() == 0) checkOutput("b_unexpected_pair", 32'(b_idx), 32'hDEAD);
      else begin
        eb = qb.pop_front();
        checkOutput("b_idx", 32'(b_idx), 32'(eb.idx));
        checkOutput("b_lambda", 32'(b_lambda), 32'(eb.lam));
        checkOutput("b_omega", 32'(b_omega), 32'(eb.omg));
        checkOutput("b_done", 32'(b_done), 32'(eb.last));
        if (eb.last) begin
          checkOutput("b_err_cnt", 32'(b_err), 32'(eb.err));
          checkOutput("b_fail", 32'(b_fail), 32'(eb.fl));
        end
      end
    end
  end

  // Loads all syndromes with sv and queues the expected Lambda=(l0,l1,0..), Omega=(o0,0..)
  task automatic applyStimulus(input logic [7:0] sv, input logic [7:0] l0, input logic [7:0] l1,
                               input logic [7:0] o0, input logic [6:0] ec, input logic fl,
                               input bit poke);
    int cyc;
    bit seen;
    pair_t p;
    for (int k = 0; k <= T; k++) begin
      p.idx  = 6'(k);
      p.lam  = (k == 0) ? l0 : (k == 1) ? l1 : 8'h00;
      p.omg  = (k == 0) ? o0 : 8'h00;
      p.last = (k == T);
      p.err  = ec;
      p.fl   = fl;
      q.push_back(p);
    end
    @(posedge clk); #1;
    synd_in = {NSYM{sv}};
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    while (!out_valid && cyc < 300) begin
      if (poke && cyc == 5) begin
        start   = 1'b1;
        synd_in = {NSYM{8'hA7}};
      end else start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    checkOutput("latency", 32'(cyc), 32'(2 + 2*NSYM + T));
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    checkOutput("idle_after_done", 32'(busy), 32'd0);
    checkOutput("sb_leftover", 32'(q.size()), 32'd0);
  endtask

  initial begin
    pair_t p;
    bit seen;
    clrn = 1'b0; clear = 1'b0; start = 1'b0; synd_in = '0;
    b_clear = 1'b0; b_start = 1'b0; b_synd = '0; b_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err_cnt), 32'd0);
    checkOutput("rst_fail", 32'(fail), 32'd0);
    checkOutput("rst_lambda", 32'(lambda_out), 32'd0);
    checkOutput("rst_idx", 32'(out_idx), 32'd0);
    clrn = 1'b1;

    applyStimulus(8'h01, 8'h01, 8'h01, 8'h01, 7'd1, 1'b0, 1'b0);
    applyStimulus(8'h05, 8'h05, 8'h05, 8'h11, 7'd1, 1'b0, 1'b1);
    applyStimulus(8'h00, 8'h01, 8'h00, 8'h00, 7'd0, 1'b0, 1'b0);
    readyMode = 1;
    applyStimulus(8'h01, 8'h01, 8'h01, 8'h01, 7'd1, 1'b0, 1'b0);
    readyMode = 0;
    @(posedge clk);

    // NSYM=4, single S0=1: Lambda collapses to degree 0 while L=1
    for (int k = 0; k <= 2; k++) begin
      p.idx = 6'(k); p.lam = (k == 0) ? 8'h01 : 8'h00; p.omg = (k == 0) ? 8'h01 : 8'h00;
      p.last = (k == 2); p.err = 7'd1; p.fl = 1'b1;
      qb.push_back(p);
    end
    @(posedge clk); #1;
    b_synd = {8'h00, 8'h00, 8'h00, 8'h01};
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (b_done) seen = 1'b1;
    end
    checkOutput("b_done_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    checkOutput("b_sb_leftover", 32'(qb.size()), 32'd0);

    // Asynchronous reset in the middle of the iteration
    synd_in = {NSYM{8'h01}};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    clrn = 1'b0;
    #1;
    checkOutput("abort_rst_busy", 32'(busy), 32'd0);
    checkOutput("abort_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    clrn = 1'b1;
    applyStimulus(8'h01, 8'h01, 8'h01, 8'h01, 7'd1, 1'b0, 1'b0);

    // Stall the output, check the held pair, then abort with clear
    readyMode = 2;
    @(posedge clk); #1;
    synd_in = {NSYM{8'h01}};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checkOutput("stall_valid", 32'(seen), 32'd1);
    checkOutput("stall_idx", 32'(out_idx), 32'd0);
    checkOutput("stall_lambda", 32'(lambda_out), 32'h01);
    checkOutput("stall_omega", 32'(omega_out), 32'h01);
    repeat (3) @(negedge clk);
    checkOutput("hold_idx", 32'(out_idx), 32'd0);
    checkOutput("hold_lambda", 32'(lambda_out), 32'h01);
    checkOutput("hold_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checkOutput("abort_clr_busy", 32'(busy), 32'd0);
    checkOutput("abort_clr_valid", 32'(out_valid), 32'd0);
    readyMode = 0;
    @(posedge clk);
    applyStimulus(8'h01, 8'h01, 8'h01, 8'h01, 7'd1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
